// File: rtl/btn_led_pkg.sv
// Shared types and helpers for the button-to-LED controller.
// Mode constants, debounce counter sizing and the accepted-level type.
package btn_led_pkg;

    localparam logic MODE_MOMENTARY = 1'b0;
    localparam logic MODE_TOGGLE    = 1'b1;

    typedef enum logic {
        DB_RELEASED = 1'b0,
        DB_PRESSED  = 1'b1
    } db_state_e;

    function automatic int DB_CNT_W(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/btn_led_ctrl_ch.sv
// One button/LED channel: synchroniser, debounce counter,
// LED register and press/release strobes.
module btn_debounce_ch
    import btn_led_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter bit BTN_ACTIVE_HIGH = 1'b1
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_btn,
    input  logic i_toggle_mode,
    output logic o_led,
    output logic o_press,
    output logic o_release
);

    localparam int            CW      = DB_CNT_W(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic          IDLE    = BTN_ACTIVE_HIGH ? 1'b0 : 1'b1;

    logic          sync1_q, sync2_q;
    logic          pressed_q, pressed_d;
    db_state_e     db_q, db_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          led_q, led_d;
    logic          press_q, press_d;
    logic          rel_q, rel_d;

    assign pressed_d = BTN_ACTIVE_HIGH ? sync2_q : ~sync2_q;

    always_comb begin
        db_d    = db_q;
        cnt_d   = cnt_q;
        press_d = 1'b0;
        rel_d   = 1'b0;
        if (pressed_q == logic'(db_q)) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
            db_d    = pressed_q ? DB_PRESSED : DB_RELEASED;
            cnt_d   = '0;
            press_d = pressed_q;
            rel_d   = ~pressed_q;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end

        if (i_toggle_mode == MODE_TOGGLE) begin
            led_d = press_d ? ~led_q : led_q;
        end else begin
            led_d = (db_d == DB_PRESSED);
        end
    end

    // Sync flops reset to the idle pin level so an active-low
    // button does not look pressed right after reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sync1_q   <= IDLE;
            sync2_q   <= IDLE;
            pressed_q <= 1'b0;
            db_q      <= DB_RELEASED;
            cnt_q     <= '0;
            led_q     <= 1'b0;
            press_q   <= 1'b0;
            rel_q     <= 1'b0;
        end else begin
            sync1_q   <= i_btn;
            sync2_q   <= sync1_q;
            pressed_q <= pressed_d;
            db_q      <= db_d;
            cnt_q     <= cnt_d;
            led_q     <= led_d;
            press_q   <= press_d;
            rel_q     <= rel_d;
        end
    end

    assign o_led     = led_q;
    assign o_press   = press_q;
    assign o_release = rel_q;

endmodule

// File: rtl/btn_led_ctrl.sv
// Multi-channel button-to-LED controller.
// One independent debounce channel per button.
module btn_led_ctrl
    import btn_led_pkg::*;
#(
    parameter int CHANNELS        = 1,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter bit BTN_ACTIVE_HIGH = 1'b1
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic [CHANNELS-1:0] i_btn,
    input  logic [CHANNELS-1:0] i_toggle_mode,
    output logic [CHANNELS-1:0] o_led,
    output logic [CHANNELS-1:0] o_press,
    output logic [CHANNELS-1:0] o_release
);

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        btn_debounce_ch #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .BTN_ACTIVE_HIGH(BTN_ACTIVE_HIGH)
        ) u_ch (
            .i_clk        (i_clk),
            .i_rst        (i_rst),
            .i_btn        (i_btn[g]),
            .i_toggle_mode(i_toggle_mode[g]),
            .o_led        (o_led[g]),
            .o_press      (o_press[g]),
            .o_release    (o_release[g])
        );
    end

endmodule

// File: tb/tb_btn_led_ctrl.sv
// Bench for btn_led_ctrl: directed scenarios plus random stimulus
// against a sliding-window reference model.
module tb_btn_led_ctrl;

    localparam int CH = 2;
    localparam int DC = 4;
    localparam bit AH = 1'b1;

    logic          clk = 1'b0;
    logic          rst;
    logic [CH-1:0] btn, tmode;
    logic [CH-1:0] led, press, rel;

    always #5 clk = ~clk;

    btn_led_ctrl #(
        .CHANNELS       (CH),
        .DEBOUNCE_CYCLES(DC),
        .BTN_ACTIVE_HIGH(AH)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_btn        (btn),
        .i_toggle_mode(tmode),
        .o_led        (led),
        .o_press      (press),
        .o_release    (rel)
    );

    int checks = 0;
    int errors = 0;
    int npress[CH];
    int nrel[CH];

    logic [CH-1:0] rawq[$];
    logic [CH-1:0] seenq[$];
    logic [CH-1:0] m_db, m_led, m_press, m_rel;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h @%0t",
                     tag, got, exp, $time);
        end
    endtask

    // A level change is accepted once the last DC levels seen after
    // the 3-stage input pipeline all differ from the accepted level.
    task automatic model_step(input logic r,
                              input logic [CH-1:0] b,
                              input logic [CH-1:0] tm);
        logic [CH-1:0] seen;
        bit            all;
        m_press = '0;
        m_rel   = '0;
        if (r) begin
            rawq  = '{};
            repeat (3) rawq.push_back('0);
            seenq = '{};
            m_db  = '0;
            m_led = '0;
            return;
        end
        seen = rawq.pop_front();
        rawq.push_back(AH ? b : ~b);
        seenq.push_back(seen);
        if (seenq.size() > DC) void'(seenq.pop_front());
        for (int c = 0; c < CH; c++) begin
            all = (seenq.size() == DC);
            foreach (seenq[k]) if (seenq[k][c] == m_db[c]) all = 0;
            if (all) begin
                m_db[c]    = ~m_db[c];
                m_press[c] = m_db[c];
                m_rel[c]   = ~m_db[c];
            end
            if (tm[c]) begin
                if (m_press[c]) m_led[c] = ~m_led[c];
            end else begin
                m_led[c] = m_db[c];
            end
        end
    endtask

    task automatic cycle(input int n);
        repeat (n) begin
            @(posedge clk);
            model_step(rst, btn, tmode);
            #1;
            check("led", led, m_led);
            check("press", press, m_press);
            check("release", rel, m_rel);
            check("excl", press & rel, 0);
            for (int c = 0; c < CH; c++) begin
                npress[c] += press[c];
                nrel[c]   += rel[c];
            end
        end
    endtask

    task automatic measure(input logic [CH-1:0] mask, input bit want_rel,
                           input string tag, input int exp);
        int n;
        bit hit;
        n   = 0;
        hit = 0;
        while (!hit && n < 30) begin
            cycle(1);
            if (((want_rel ? rel : press) & mask) == mask) hit = 1;
            else n++;
        end
        check(tag, hit ? n : -1, exp);
    endtask

    initial begin
        logic [2:0] exp_seq;
        rst   = 1'b1;
        btn   = '0;
        tmode = '0;
        cycle(2);
        check("rst_led", led, 0);
        check("rst_strobe", {press, rel}, 0);
        rst = 1'b0;
        cycle(3);

        // clean press/release, momentary
        btn[0] = 1'b1;
        measure(2'b01, 1'b0, "s1_press_lat", 6);
        check("s1_led_on", led[0], 1);
        cycle(5);
        btn[0] = 1'b0;
        measure(2'b01, 1'b1, "s1_rel_lat", 6);
        check("s1_led_off", led[0], 0);
        cycle(5);

        // short pulse rejected
        npress = '{default: 0};
        btn[0] = 1'b1;
        cycle(3);
        btn[0] = 1'b0;
        cycle(8);
        check("s2_no_strobe", npress[0], 0);
        btn[0] = 1'b1;
        measure(2'b01, 1'b0, "s2_press_lat", 6);
        btn[0] = 1'b0;
        cycle(12);

        // toggle mode, ch1
        tmode[1] = 1'b1;
        npress   = '{default: 0};
        nrel     = '{default: 0};
        exp_seq  = 3'b101;
        for (int i = 0; i < 3; i++) begin
            btn[1] = 1'b1;
            cycle(10);
            check("s3_led_press", led[1], exp_seq[i]);
            btn[1] = 1'b0;
            cycle(10);
            check("s3_led_rel", led[1], exp_seq[i]);
        end
        check("s3_npress", npress[1], 3);
        check("s3_nrel", nrel[1], 3);

        // mode switch with led=1, released
        tmode[1] = 1'b0;
        cycle(1);
        check("s4_to_mom", led[1], 0);
        tmode[1] = 1'b1;
        cycle(3);
        check("s4_to_tog", led[1], 0);
        tmode[1] = 1'b0;
        cycle(2);

        // reset mid-count
        btn[0] = 1'b1;
        cycle(3);
        rst = 1'b1;
        cycle(1);
        check("s5_rst_out", {led, press, rel}, 0);
        rst = 1'b0;
        measure(2'b01, 1'b0, "s5_press_lat", 6);
        btn[0] = 1'b0;
        cycle(12);

        // simultaneous channels
        btn = 2'b11;
        measure(2'b11, 1'b0, "s6_press_lat", 6);
        check("s6_both", press, 2'b11);
        cycle(1);
        check("s6_one_cycle", press, 0);
        btn = 2'b00;
        cycle(12);

        // random stimulus with bounces, mode flips and resets
        for (int i = 0; i < 4000; i++) begin
            for (int c = 0; c < CH; c++) begin
                if ($urandom_range(0, 9) == 0) btn[c] = ~btn[c];
                if ($urandom_range(0, 199) == 0) tmode[c] = ~tmode[c];
            end
            rst = ($urandom_range(0, 599) == 0);
            cycle(1);
        end
        rst = 1'b0;
        cycle(2);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
